// File: rtl/motion_pkg.sv
// Shared constants and the x-axis FSM encoding for the motion controller.
package motion_pkg;

   localparam int XMODE_WRAP   = 0;
   localparam int XMODE_BOUNCE = 1;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // The state encoding doubles as the x_dir output bit.
   typedef enum logic {
      ST_FWD = 1'b0,
      ST_REV = 1'b1
   } x_state_t;

endpackage

// File: rtl/motion_ctrl_param_if.sv
// Control inputs and position outputs of motion_ctrl_param.
// The master side drives steering and enable; the slave side is the controller.
interface motion_ctrl_param_if #(
   parameter int XW = 9,
   parameter int YW = 10
);
   logic          enable;
   logic          left;
   logic          right;
   logic [XW-1:0] x_pos;
   logic [YW-1:0] y_pos;
   logic          x_dir;
   logic          x_edge;
   logic          at_y_min;
   logic          at_y_max;

   modport master (
      output enable, left, right,
      input  x_pos, y_pos, x_dir, x_edge, at_y_min, at_y_max
   );

   modport slave (
      input  enable, left, right,
      output x_pos, y_pos, x_dir, x_edge, at_y_min, at_y_max
   );
endinterface

// File: rtl/tick_divider.sv
// Prescaler: one-cycle tick every TICK_DIV enabled clocks. Disabled cycles
// freeze the count, so the tick phase survives an enable gap.
module tick_divider #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_reg;

   if (TICK_DIV < 1) begin : g_bad_div
      $error("tick_divider: TICK_DIV must be >= 1");
   end

   assign tick = enable && (cnt_reg == CW'(TICK_DIV - 1));

   // Count enabled cycles, restarting at 0 on each tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       cnt_reg <= '0;
      else if (tick)   cnt_reg <= '0;
      else if (enable) cnt_reg <= cnt_reg + 1'b1;
   end
endmodule

// File: rtl/motion_ctrl_param.sv
// Ball/paddle position updater: x auto-advances (wrap or bounce) on each
// motion tick, y is steered by left/right and clamped to [Y_MIN, Y_MAX].
// Optional feature macro: MOTION_CTRL_ACCEL_EN doubles the y step after
// ACCEL_TICKS consecutive ticks held in one direction.
import motion_pkg::*;

module motion_ctrl_param #(
   parameter int XW          = 9,
   parameter int YW          = 10,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 63,
   parameter int Y_MIN       = 84,
   parameter int Y_MAX       = 596,
   parameter int Y_INIT      = 340,
   parameter int STEP        = 1,
   parameter int TICK_DIV    = 1,
   parameter int X_MODE      = 0,
   parameter int ACCEL_TICKS = 8
) (
   input logic               clk,
   input logic               reset,
   motion_ctrl_param_if.slave bus
);
   // Two spare bits so Y_MIN + 2*STEP and y + 2*STEP never overflow.
   localparam int YX = YW + 2;

   if (Y_INIT < Y_MIN || Y_INIT > Y_MAX) begin : g_bad_init
      $error("motion_ctrl_param: Y_INIT outside [Y_MIN, Y_MAX]");
   end
   if (STEP < 1 || STEP > Y_MAX - Y_MIN) begin : g_bad_step
      $error("motion_ctrl_param: STEP outside [1, Y_MAX-Y_MIN]");
   end
   if (X_MAX <= X_MIN) begin : g_bad_x
      $error("motion_ctrl_param: X_MAX must exceed X_MIN");
   end
   if (X_MODE != XMODE_WRAP && X_MODE != XMODE_BOUNCE) begin : g_bad_mode
      $error("motion_ctrl_param: X_MODE must be 0 or 1");
   end

   logic          tick;
   x_state_t      state_reg, state_next;
   logic [XW-1:0] x_reg, x_next;
   logic [YW-1:0] y_reg, y_next;
   logic          edge_reg, edge_next;
   logic          at_min_reg, at_max_reg;
   logic [YX-1:0] step_eff;
   logic [YX-1:0] y_wide, y_sum, low_bound;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable),
      .tick   (tick)
   );

`ifdef MOTION_CTRL_ACCEL_EN
   localparam int HW = $clog2(ACCEL_TICKS + 1);

   logic [HW-1:0] hold_reg, hold_next;
   logic          hold_dir_reg, hold_dir_next;

   if (ACCEL_TICKS < 1) begin : g_bad_accel
      $error("motion_ctrl_param: ACCEL_TICKS must be >= 1");
   end

   // Track how long one direction has been held; a direction change
   // starts a fresh run with the changing tick counted as its first.
   always_comb begin
      hold_next     = hold_reg;
      hold_dir_next = hold_dir_reg;
      if (tick) begin
         if (bus.left ^ bus.right) begin
            hold_dir_next = bus.right;
            if (bus.right != hold_dir_reg)          hold_next = HW'(1);
            else if (hold_reg < HW'(ACCEL_TICKS))   hold_next = hold_reg + 1'b1;
         end else begin
            hold_next = '0;
         end
      end
   end

   // Step doubles only once the run has saturated.
   always_comb begin
      step_eff = (hold_reg == HW'(ACCEL_TICKS)) ? YX'(2 * STEP) : YX'(STEP);
   end

   // Hold-run counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_reg     <= '0;
         hold_dir_reg <= 1'b0;
      end else begin
         hold_reg     <= hold_next;
         hold_dir_reg <= hold_dir_next;
      end
   end
`else
   assign step_eff = YX'(STEP);
`endif

   // Next-state logic for both axes; everything holds outside tick cycles.
   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      edge_next  = 1'b0;
      y_wide     = YX'(y_reg);
      y_sum      = y_wide + step_eff;
      low_bound  = YX'(Y_MIN) + step_eff;
      if (tick) begin
         if (X_MODE == XMODE_BOUNCE) begin
            case (state_reg)
               ST_FWD: begin
                  if (x_reg == XW'(X_MAX)) begin
                     state_next = ST_REV;
                     x_next     = XW'(X_MAX - 1);
                     edge_next  = 1'b1;
                  end else begin
                     x_next = x_reg + 1'b1;
                  end
               end
               ST_REV: begin
                  if (x_reg == XW'(X_MIN)) begin
                     state_next = ST_FWD;
                     x_next     = XW'(X_MIN + 1);
                     edge_next  = 1'b1;
                  end else begin
                     x_next = x_reg - 1'b1;
                  end
               end
               default: state_next = ST_FWD;
            endcase
         end else begin
            if (x_reg == XW'(X_MAX)) begin
               x_next    = XW'(X_MIN);
               edge_next = 1'b1;
            end else begin
               x_next = x_reg + 1'b1;
            end
         end
         // Compare before stepping so the downward move cannot underflow.
         if (bus.left && !bus.right) begin
            y_next = (y_wide < low_bound) ? YW'(Y_MIN) : YW'(y_wide - step_eff);
         end else if (bus.right && !bus.left) begin
            y_next = (y_sum > YX'(Y_MAX)) ? YW'(Y_MAX) : YW'(y_sum);
         end
      end
   end

   // Position, direction and flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_FWD;
         x_reg      <= XW'(X_MIN);
         y_reg      <= YW'(Y_INIT);
         edge_reg   <= 1'b0;
         at_min_reg <= (Y_INIT == Y_MIN);
         at_max_reg <= (Y_INIT == Y_MAX);
      end else begin
         state_reg  <= state_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
         edge_reg   <= edge_next;
         at_min_reg <= (y_next == YW'(Y_MIN));
         at_max_reg <= (y_next == YW'(Y_MAX));
      end
   end

   assign bus.x_pos    = x_reg;
   assign bus.y_pos    = y_reg;
   assign bus.x_dir    = state_reg;
   assign bus.x_edge   = edge_reg;
   assign bus.at_y_min = at_min_reg;
   assign bus.at_y_max = at_max_reg;
endmodule

// File: tb/tb_motion_ctrl_param.sv
// Directed bench for motion_ctrl_param: four instances cover wrap, bounce,
// y clamping with STEP=5, and a TICK_DIV=4 prescaler. Expectations adapt to
// MOTION_CTRL_ACCEL_EN where the step doubling changes the result.
module tb_motion_ctrl_param;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   motion_ctrl_param_if #(.XW(9), .YW(10)) w_if ();
   motion_ctrl_param_if #(.XW(9), .YW(10)) b_if ();
   motion_ctrl_param_if #(.XW(9), .YW(10)) c_if ();
   motion_ctrl_param_if #(.XW(9), .YW(10)) d_if ();

   motion_ctrl_param u_wrap (.clk(clk), .reset(reset), .bus(w_if));
   motion_ctrl_param #(.X_MODE(1)) u_bounce (.clk(clk), .reset(reset), .bus(b_if));
   motion_ctrl_param #(.STEP(5), .Y_INIT(86)) u_clamp (.clk(clk), .reset(reset), .bus(c_if));
   motion_ctrl_param #(.TICK_DIV(4)) u_div (.clk(clk), .reset(reset), .bus(d_if));

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int y_exp;
      reset = 1'b1;
      w_if.enable = 0; w_if.left = 0; w_if.right = 0;
      b_if.enable = 0; b_if.left = 0; b_if.right = 0;
      c_if.enable = 0; c_if.left = 0; c_if.right = 0;
      d_if.enable = 0; d_if.left = 0; d_if.right = 0;

      // Reset values before any clock edge.
      #2;
      check("rst_x", w_if.x_pos, 0);
      check("rst_y", w_if.y_pos, 340);
      check("rst_dir", w_if.x_dir, 0);
      check("rst_edge", w_if.x_edge, 0);
      check("rst_clamp_y", c_if.y_pos, 86);
      cycles(2);
      reset = 1'b0;

      // Enable low: nothing moves.
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         check("hold_edge", w_if.x_edge, 0);
      end
      check("hold_x", w_if.x_pos, 0);
      check("hold_y", w_if.y_pos, 340);
      check("hold_dir", w_if.x_dir, 0);
      check("hold_min", w_if.at_y_min, 0);
      check("hold_max", w_if.at_y_max, 0);

      // Wrap mode at TICK_DIV=1.
      w_if.enable = 1;
      cycles(63);
      check("wrap_x63", w_if.x_pos, 63);
      check("wrap_edge63", w_if.x_edge, 0);
      cycles(1);
      check("wrap_x0", w_if.x_pos, 0);
      check("wrap_edge", w_if.x_edge, 1);
      check("wrap_dir", w_if.x_dir, 0);
      cycles(1);
      check("wrap_x1", w_if.x_pos, 1);
      check("wrap_edge_off", w_if.x_edge, 0);

      // Held right from 340: step doubling appears on tick 9 with the feature.
      w_if.right = 1;
      cycles(8);
      check("accel_y8", w_if.y_pos, 348);
      cycles(1);
`ifdef MOTION_CTRL_ACCEL_EN
      y_exp = 350;
`else
      y_exp = 349;
`endif
      check("accel_y9", w_if.y_pos, y_exp);
      w_if.right = 0;
      cycles(1);
      check("accel_release", w_if.y_pos, y_exp);
      w_if.right = 1;
      cycles(1);
      check("accel_restart", w_if.y_pos, y_exp + 1);
      w_if.right = 0;
      w_if.enable = 0;

      // Bounce mode.
      b_if.enable = 1;
      cycles(62);
      check("bnc_x62", b_if.x_pos, 62);
      cycles(1);
      check("bnc_x63", b_if.x_pos, 63);
      check("bnc_dir63", b_if.x_dir, 0);
      check("bnc_edge63", b_if.x_edge, 0);
      cycles(1);
      check("bnc_rev_x", b_if.x_pos, 62);
      check("bnc_rev_dir", b_if.x_dir, 1);
      check("bnc_rev_edge", b_if.x_edge, 1);
      cycles(1);
      check("bnc_x61", b_if.x_pos, 61);
      check("bnc_edge61", b_if.x_edge, 0);
      cycles(61);
      check("bnc_x0", b_if.x_pos, 0);
      check("bnc_dir0", b_if.x_dir, 1);
      check("bnc_edge0", b_if.x_edge, 0);
      cycles(1);
      check("bnc_fwd_x", b_if.x_pos, 1);
      check("bnc_fwd_dir", b_if.x_dir, 0);
      check("bnc_fwd_edge", b_if.x_edge, 1);
      check("bnc_y", b_if.y_pos, 340);
      b_if.enable = 0;

      // Clamp with STEP=5 from Y_INIT=86.
      c_if.enable = 1;
      c_if.left = 1;
      cycles(1);
      check("clamp_min_y", c_if.y_pos, 84);
      check("clamp_min_flag", c_if.at_y_min, 1);
      cycles(1);
      check("clamp_min_hold", c_if.y_pos, 84);
      check("clamp_min_flag2", c_if.at_y_min, 1);
      c_if.left = 0;
      cycles(1);
      c_if.right = 1;
`ifdef MOTION_CTRL_ACCEL_EN
      cycles(55);   // 8 ticks of 5 to 124, then 47 ticks of 10
`else
      cycles(102);
`endif
      check("clamp_594", c_if.y_pos, 594);
      check("clamp_594_max", c_if.at_y_max, 0);
      check("clamp_594_min", c_if.at_y_min, 0);
      cycles(1);
      check("clamp_max_y", c_if.y_pos, 596);
      check("clamp_max_flag", c_if.at_y_max, 1);
      cycles(1);
      check("clamp_max_hold", c_if.y_pos, 596);
      check("clamp_max_flag2", c_if.at_y_max, 1);
      c_if.right = 0;
      c_if.enable = 0;

      // Prescaler TICK_DIV=4.
      d_if.enable = 1;
      d_if.right = 1;
      cycles(3);
      check("div_y_c3", d_if.y_pos, 340);
      cycles(1);
      check("div_y_c4", d_if.y_pos, 341);
      cycles(3);
      check("div_y_c7", d_if.y_pos, 341);
      cycles(1);
      check("div_y_c8", d_if.y_pos, 342);
      check("div_x_c8", d_if.x_pos, 2);
      d_if.left = 1;
      cycles(8);
      check("div_both_y", d_if.y_pos, 342);
      check("div_both_x", d_if.x_pos, 4);
      d_if.left = 0;

      // Asynchronous reset mid-run, away from any clock edge.
      #2 reset = 1'b1;
      #1;
      check("async_rst_y", d_if.y_pos, 340);
      check("async_rst_x", d_if.x_pos, 0);
      check("async_rst_clamp_y", c_if.y_pos, 86);
      cycles(1);
      reset = 1'b0;
      cycles(3);
      check("post_rst_c3", d_if.y_pos, 340);
      cycles(1);
      check("post_rst_c4", d_if.y_pos, 341);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/motion_ctrl_param.md
Name: motion_ctrl_param

Overview:
- Parametrised successor to the ball/paddle position updater.
- X axis auto-advances on a prescaled tick and either wraps or bounces between limits.
- Y axis is steered by left/right with a configurable step, clamped to [Y_MIN, Y_MAX].
- Feeds the VGA renderer and the collision logic with registered positions and edge flags.

Parameters:
- XW, 9, x_pos width
- YW, 10, y_pos width
- X_MIN, 0, lowest x value
- X_MAX, 63, highest x value
- Y_MIN, 84, lowest y value
- Y_MAX, 596, highest y value
- Y_INIT, 340, y value on reset; must lie in [Y_MIN, Y_MAX]
- STEP, 1, y increment per tick; must satisfy 1 <= STEP <= Y_MAX-Y_MIN
- TICK_DIV, 1, clk cycles per motion tick; must be >= 1
- X_MODE, 0, 0 = wrap, 1 = bounce
- ACCEL_TICKS, 8, consecutive held ticks before acceleration; used only with ACCEL_EN

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = prescaler runs; 0 = freeze all motion state
- left  in  1  move y down, toward Y_MIN
- right  in  1  move y up, toward Y_MAX
- x_pos  out  XW  registered x position
- y_pos  out  YW  registered y position
- x_dir  out  1  0 = x incrementing, 1 = x decrementing; stays 0 in wrap mode
- x_edge  out  1  one-cycle pulse when x wraps or reverses
- at_y_min  out  1  registered; 1 iff y_pos == Y_MIN
- at_y_max  out  1  registered; 1 iff y_pos == Y_MAX

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - x_pos = X_MIN, x_dir = 0, y_pos = Y_INIT, x_edge = 0
  - div_cnt = 0, hold_cnt = 0
  - at_y_min and at_y_max reflect Y_INIT
- Reset asserted mid-operation aborts any tick immediately. The first tick after release occurs TICK_DIV enabled cycles later.
- Prescaler:
  - div_cnt counts 0..TICK_DIV-1 while enable = 1.
  - tick = enable && (div_cnt == TICK_DIV-1); div_cnt then returns to 0.
  - enable = 0 holds div_cnt and all positions unchanged.
  - TICK_DIV = 1 gives a tick on every enabled cycle.
- All updates are registered. Inputs sampled in the tick cycle appear on the outputs the following cycle (latency 1). Nothing changes on non-tick cycles, except that x_edge returns to 0.
- X, wrap mode (X_MODE = 0):
  - x increments by 1 each tick.
  - At X_MAX the next value is X_MIN, and x_edge pulses.
- X, bounce mode (X_MODE = 1). Two-state FSM: FWD (x_dir = 0) and REV (x_dir = 1).
  - FWD: x+1. At X_MAX, go to REV, next x = X_MAX-1, x_edge pulses.
  - REV: x-1. At X_MIN, go to FWD, next x = X_MIN+1, x_edge pulses.
  - X_MAX-X_MIN == 1 degenerates to alternating between the two values, with x_edge pulsing every tick.
- Y, evaluated on tick only:
  - left = 1, right = 0: y = Y_MIN if y < Y_MIN+STEP, else y-STEP. Compare before subtracting; no unsigned underflow.
  - right = 1, left = 0: y = Y_MAX if y > Y_MAX-STEP, else y+STEP.
  - Both or neither: hold.
  - Pressing toward a limit while already at it: hold, flag stays 1.
- at_y_min and at_y_max are updated in the same cycle as y_pos.
- X and Y updates are independent and happen on the same tick.

Optional Feature:
- Macro: MOTION_CTRL_ACCEL_EN
- Defined:
  - hold_cnt counts consecutive ticks with the same single direction held. It saturates at ACCEL_TICKS.
  - hold_cnt clears on release, on both pressed, or on a direction change.
  - When hold_cnt == ACCEL_TICKS, the effective step is 2*STEP. The same clamp rules apply using 2*STEP.
  - The first ACCEL_TICKS held ticks use STEP; the doubled step starts on the next tick.
- Undefined:
  - No hold_cnt register; step is always STEP.
  - ACCEL_TICKS is ignored.

Decomposition:
- Package motion_pkg holds:
  - XMODE_WRAP = 0, XMODE_BOUNCE = 1
  - DIR_FWD = 0, DIR_REV = 1
  - the FSM state encoding
- Sub-module tick_divider (parameter TICK_DIV) contains the prescaler.
  - Inputs: clk, reset, enable. Output: tick.
  - It is reused by the other timed objects.
- Parameter legality is checked by elaboration-time assertions.

Test Plan:
- Reset/hold: assert reset, release, keep enable = 0 for 20 cycles. Expect x_pos = 0, y_pos = 340, x_dir = 0, x_edge never asserted, flags 0.
- Wrap mode (TICK_DIV = 1, enable = 1): after 63 ticks x_pos = 63; next tick x_pos = 0 with a single-cycle x_edge pulse.
- Bounce mode: x runs 62, 63, 62; x_dir goes 1 on the 63→62 transition and x_edge pulses. At 0 x_dir returns to 0 and the next value is 1.
- Y clamp (STEP = 5, Y_INIT = 86): hold left. Expect y 86→84, at_y_min = 1, then y stays 84. Hold right from 594: expect 596, at_y_max = 1, then y holds.
- Prescaler/conflict (TICK_DIV = 4): right held, y steps once every 4 cycles. left and right both held: y constant. A mid-run reset returns y to 340 asynchronously.
- MOTION_CTRL_ACCEL_EN (STEP = 1, ACCEL_TICKS = 8): hold right from 340. Ticks 1-8 reach 348; tick 9 gives 350. Release for one tick, then press again: step is back to 1.
